// File: rtl/bfs_path_tracer.sv
// bfs_path_tracer: walks the BFS parent-direction map from a terminal
// cell back to the origin, streaming coordinates and counting steps.
module bfs_path_tracer #(
  parameter int depth     = 21,
  parameter int x_width   = 10,
  parameter int max_steps = 1023,
  parameter int len_w     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear_en,
  input  logic [x_width:0] term_x,
  input  logic [x_width:0] term_y,
  input  logic [x_width:0] orig_x,
  input  logic [x_width:0] orig_y,
  input  logic [3:0]       ram_in,
  output logic [depth:0]   ram_addr,
  output logic [3:0]       ram_out,
  output logic             ram_write_en,
  output logic             path_valid,
  input  logic             path_ready,
  output logic [x_width:0] path_x,
  output logic [x_width:0] path_y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [len_w:0]   path_len
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EMIT = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] LAT  = 3'd3;
  localparam logic [2:0] EVAL = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [len_w:0] MAX_LEN = (len_w+1)'(max_steps);
  localparam logic [len_w:0] ONE_L = {{len_w{1'b0}}, 1'b1};
  localparam logic [x_width:0] ONE_C = {{x_width{1'b0}}, 1'b1};

  localparam logic [1:0] ST_ORIG  = 2'd0;
  localparam logic [1:0] ST_BAD   = 2'd1;
  localparam logic [1:0] ST_LIMIT = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [x_width:0] x_q, x_d;
  logic [x_width:0] y_q, y_d;
  logic [x_width:0] ox_q, ox_d;
  logic [x_width:0] oy_q, oy_d;
  logic             clr_q, clr_d;
  logic [2:0]       code_q, code_d;
  logic [len_w:0]   len_q, len_d;
  logic [1:0]       status_q, status_d;

  logic             at_orig;
  logic             code_ok;
  logic             ram_acc;
  logic [len_w:0]   len_inc;
  logic [depth:0]   addr_cur;
  logic             unused_ram_msb;

  assign unused_ram_msb = ram_in[3];

  assign at_orig = (x_q == ox_q) && (y_q == oy_q);
  assign code_ok = (code_q >= 3'd1) && (code_q <= 3'd4);
  assign len_inc = len_q + ONE_L;

  // Only the low y bits reach the address, matching the BFS layout.
  assign addr_cur = {1'b1, y_q[x_width-1:0], x_q};

  assign ram_acc = (state_q == RD) || (state_q == LAT) ||
                   (state_q == EVAL);

  assign ram_addr     = ram_acc ? addr_cur : '0;
  assign ram_out      = 4'd0;
  assign ram_write_en = (state_q == EVAL) && clr_q && code_ok;

  assign path_valid = (state_q == EMIT);
  assign path_x     = x_q;
  assign path_y     = y_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign status     = status_q;
  assign path_len   = len_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    clr_d    = clr_q;
    code_d   = code_q;
    len_d    = len_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = term_x;
          y_d      = term_y;
          ox_d     = orig_x;
          oy_d     = orig_y;
          clr_d    = clear_en;
          len_d    = '0;
          status_d = ST_ORIG;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (path_ready) begin
          if (at_orig) begin
            status_d = ST_ORIG;
            state_d  = DONE;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = LAT;
      LAT: begin
        code_d  = ram_in[2:0];
        state_d = EVAL;
      end
      EVAL: begin
        // Step opposite to the direction BFS moved into this cell.
        unique case (1'b1)
          (code_q == 3'd1): y_d = y_q + ONE_C;
          (code_q == 3'd2): y_d = y_q - ONE_C;
          (code_q == 3'd3): x_d = x_q + ONE_C;
          (code_q == 3'd4): x_d = x_q - ONE_C;
          default: ;
        endcase
        if (!code_ok) begin
          status_d = ST_BAD;
          state_d  = DONE;
        end else begin
          len_d = len_inc;
          if (len_inc == MAX_LEN) begin
            status_d = ST_LIMIT;
            state_d  = DONE;
          end else begin
            state_d = EMIT;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      clr_q    <= 1'b0;
      code_q   <= '0;
      len_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      clr_q    <= clr_d;
      code_q   <= code_d;
      len_q    <= len_d;
      status_q <= status_d;
    end
  end

endmodule
